// File: rtl/bitcoin_result_writer.sv
// Collects per-nonce H0 hash words into a local buffer, then streams them to
// memory as NUM_NONCES consecutive words starting at a latched base address.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; base and bitmap are reloaded on start
// ST_COLLECT| accepting hash beats until every nonce has been seen once
// ST_WRITE  | one memory write per cycle, idx 0..NUM_NONCES-1
// ST_DONE   | single-cycle done pulse, then back to ST_IDLE
module bitcoin_result_writer #(
   parameter int NUM_NONCES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] output_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_nonce,
   input  logic [31:0] in_hash,
   output logic        done,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_write_data
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WRITE,
      ST_DONE
   } state_t;

   localparam logic [3:0] LAST_IDX   = 4'(NUM_NONCES - 1);
   localparam logic [4:0] NONCE_LIM  = 5'(NUM_NONCES);

   state_t                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [15:0]           base_q, base_d;
   logic [NUM_NONCES-1:0] bitmap_q, bitmap_d;
   logic [31:0]           hash_buf_q [NUM_NONCES];
   logic [31:0]           hash_buf_d [NUM_NONCES];

   logic accept;
   logic nonce_ok;

   assign accept   = in_valid && (state_q == ST_COLLECT);
   assign nonce_ok = ({1'b0, in_nonce} < NONCE_LIM);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      base_d     = base_q;
      bitmap_d   = bitmap_q;
      hash_buf_d = hash_buf_q;
      case (state_q)
         ST_IDLE: begin
            idx_d = 4'd0;
            if (start) begin
               base_d   = output_addr;
               bitmap_d = '0;
               state_d  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            // Out-of-range nonces are consumed by in_ready but leave no trace.
            if (accept && nonce_ok) begin
               hash_buf_d[in_nonce] = in_hash;
               bitmap_d[in_nonce]   = 1'b1;
               if (&bitmap_d) begin
                  state_d = ST_WRITE;
                  idx_d   = 4'd0;
               end
            end
         end
         ST_WRITE: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               idx_d   = 4'd0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= 4'd0;
         base_q   <= 16'd0;
         bitmap_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         base_q   <= base_d;
         bitmap_q <= bitmap_d;
      end
   end

   // Buffer is deliberately unreset; contents carry over between jobs.
   always_ff @(posedge clk) begin
      hash_buf_q <= hash_buf_d;
   end

   assign mem_clk        = clk;
   assign in_ready       = (state_q == ST_COLLECT);
   assign done           = (state_q == ST_DONE);
   assign mem_we         = (state_q == ST_WRITE);
   assign mem_addr       = (state_q == ST_WRITE) ? (base_q + {12'd0, idx_q}) : base_q;
   assign mem_write_data = (state_q == ST_WRITE) ? hash_buf_q[idx_q] : 32'd0;

endmodule

// File: tb/tb_bitcoin_result_writer.sv
// Directed bench for bitcoin_result_writer: a table of whole jobs plus
// hand-written sequences for duplicates, mid-write reset and ignored inputs.
module tb_bitcoin_result_writer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [15:0] output_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_nonce;
   logic [31:0] in_hash;
   logic        done;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int done_cnt = 0;

   bitcoin_result_writer #(.NUM_NONCES(16)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .output_addr(output_addr),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_nonce(in_nonce),
      .in_hash(in_hash),
      .done(done),
      .mem_clk(mem_clk),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_write_data(mem_write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) wr_cnt++;
      if (done) done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] base;
      logic [31:0] hash_base;
      logic        reverse;
      logic        gaps;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
   } job_vec_t;

   job_vec_t jobs [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic start_job(input logic [15:0] addr);
      start       = 1'b1;
      output_addr = addr;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] n, input logic [31:0] h);
      in_valid = 1'b1;
      in_nonce = n;
      in_hash  = h;
      step();
   endtask

   // Called right after the completing accept edge; ends in the DONE cycle.
   task automatic expect_burst(input string nm, input logic [15:0] b, input logic [31:0] d [16],
                               output logic [15:0] first_a, output logic [15:0] last_a);
      logic [15:0] ea;
      first_a = mem_addr;
      for (int i = 0; i < 16; i++) begin
         ea = b + 16'(i);
         chk({nm, " we"}, {31'd0, mem_we}, 32'd1);
         chk({nm, " addr"}, {16'd0, mem_addr}, {16'd0, ea});
         chk({nm, " data"}, mem_write_data, d[i]);
         chk({nm, " rdy_in_write"}, {31'd0, in_ready}, 32'd0);
         last_a = mem_addr;
         step();
      end
      chk({nm, " done"}, {31'd0, done}, 32'd1);
      chk({nm, " we_in_done"}, {31'd0, mem_we}, 32'd0);
      chk({nm, " addr_in_done"}, {16'd0, mem_addr}, {16'd0, b});
      chk({nm, " data_in_done"}, mem_write_data, 32'd0);
   endtask

   initial begin
      logic [31:0] d [16];
      logic [15:0] fa, la;
      logic [3:0]  n;
      int          w0, d0;

      jobs[0] = '{16'h0100, 32'hA000_0000, 1'b0, 1'b0, 16'h0100, 16'h010F};
      jobs[1] = '{16'h0100, 32'hA000_0000, 1'b1, 1'b1, 16'h0100, 16'h010F};
      jobs[2] = '{16'hFFF8, 32'hD000_0000, 1'b0, 1'b0, 16'hFFF8, 16'h0007};
      jobs[3] = '{16'h1234, 32'h5555_0000, 1'b1, 1'b0, 16'h1234, 16'h1243};

      reset_n     = 1'b0;
      start       = 1'b0;
      output_addr = 16'h0;
      in_valid    = 1'b0;
      in_nonce    = 4'h0;
      in_hash     = 32'h0;
      step();
      step();
      chk("rst in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst mem_data", mem_write_data, 32'd0);
      chk("mem_clk high", {31'd0, mem_clk}, {31'd0, clk});
      reset_n = 1'b1;
      step();
      chk("idle in_ready", {31'd0, in_ready}, 32'd0);
      #5;
      chk("mem_clk low", {31'd0, mem_clk}, {31'd0, clk});
      step();

      // Table-driven full jobs
      for (int v = 0; v < 4; v++) begin
         start_job(jobs[v].base);
         chk("collect in_ready", {31'd0, in_ready}, 32'd1);
         chk("collect base addr", {16'd0, mem_addr}, {16'd0, jobs[v].base});
         for (int k = 0; k < 16; k++) begin
            n = jobs[v].reverse ? 4'(15 - k) : 4'(k);
            send(n, jobs[v].hash_base + 32'(n));
            if (jobs[v].gaps && k != 15) begin
               in_valid = 1'b0;
               step();
            end
         end
         in_valid = 1'b0;
         for (int i = 0; i < 16; i++) d[i] = jobs[v].hash_base + 32'(i);
         expect_burst("job", jobs[v].base, d, fa, la);
         chk("job first addr", {16'd0, fa}, {16'd0, jobs[v].exp_first});
         chk("job last addr", {16'd0, la}, {16'd0, jobs[v].exp_last});
         step();
         chk("job done one cycle", {31'd0, done}, 32'd0);
      end

      // Duplicate nonce 3: last value wins, still exactly 16 writes
      w0 = wr_cnt;
      d0 = done_cnt;
      start_job(16'h0300);
      send(4'd3, 32'h0000_1111);
      for (int k = 0; k < 16; k++)
         send(4'(k), (k == 3) ? 32'h0000_2222 : 32'hC000_0000 + 32'(k));
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) d[i] = 32'hC000_0000 + 32'(i);
      d[3] = 32'h0000_2222;
      expect_burst("dup", 16'h0300, d, fa, la);
      step();
      chk("dup write count", 32'(wr_cnt - w0), 32'd16);
      chk("dup done count", 32'(done_cnt - d0), 32'd1);

      // Reset after 8 writes abandons the job
      start_job(16'h0400);
      for (int k = 0; k < 16; k++) send(4'(k), 32'hF000_0000 + 32'(k));
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("pre-rst addr", {16'd0, mem_addr}, 32'h0400 + 32'(i));
         step();
      end
      w0 = wr_cnt;
      d0 = done_cnt;
      reset_n = 1'b0;
      #1;
      chk("async rst mem_we", {31'd0, mem_we}, 32'd0);
      chk("async rst mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("async rst data", mem_write_data, 32'd0);
      chk("async rst done", {31'd0, done}, 32'd0);
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post-rst idle rdy", {31'd0, in_ready}, 32'd0);
         chk("post-rst idle we", {31'd0, mem_we}, 32'd0);
      end
      chk("post-rst no writes", 32'(wr_cnt - w0), 32'd0);
      chk("post-rst no done", 32'(done_cnt - d0), 32'd0);
      start_job(16'h0410);
      for (int k = 0; k < 16; k++) send(4'(k), 32'h1234_0000 + 32'(k));
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) d[i] = 32'h1234_0000 + 32'(i);
      expect_burst("after-rst", 16'h0410, d, fa, la);
      step();

      // start held high through COLLECT/WRITE; in_valid during WRITE ignored
      start       = 1'b1;
      output_addr = 16'h0500;
      step();
      output_addr = 16'h0600;
      chk("held start rdy", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 16; k++) send(4'(k), 32'hE000_0000 + 32'(k));
      in_valid = 1'b1;
      in_nonce = 4'd7;
      in_hash  = 32'h0BAD_0BAD;
      for (int i = 0; i < 16; i++) d[i] = 32'hE000_0000 + 32'(i);
      expect_burst("held-start", 16'h0500, d, fa, la);
      start    = 1'b0;
      in_nonce = 4'd0;
      in_hash  = 32'hDEAD_BEEF;
      step();
      chk("idle rdy with valid", {31'd0, in_ready}, 32'd0);
      step();
      chk("idle stays idle", {31'd0, in_ready}, 32'd0);
      chk("idle no write", {31'd0, mem_we}, 32'd0);
      in_valid = 1'b0;

      // Nonce 0 offered in IDLE must not count toward the bitmap
      start_job(16'h0700);
      for (int k = 1; k < 16; k++) send(4'(k), 32'h7000_0000 + 32'(k));
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("incomplete rdy", {31'd0, in_ready}, 32'd1);
         chk("incomplete no write", {31'd0, mem_we}, 32'd0);
      end
      send(4'd0, 32'h7000_0000);
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) d[i] = 32'h7000_0000 + 32'(i);
      expect_burst("late-0", 16'h0700, d, fa, la);
      step();
      chk("final idle done", {31'd0, done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
